// File: rtl/halo_pkg.sv
// Shared types for the halo receive path: FSM states, the buffered entry layout
// and the bank mapping used by the arbiter.
// Pure declarations; no logic, no latency, no flow control.
package halo_pkg;

    localparam int NEIGHBOR_COUNT = 8;
    localparam int HALO_TILE_SIZE = 256;
    localparam int HALO_COORD_W   = $clog2(HALO_TILE_SIZE);
    localparam int HALO_VALUE_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } halo_state_e;

    typedef struct packed {
        logic [HALO_VALUE_W-1:0] value;
        logic [HALO_COORD_W-1:0] row;
        logic [HALO_COORD_W-1:0] column;
    } halo_entry_t;

    // Diagonal interleave: (row + column) mod bank_count, bank_count a power of 2.
    function automatic logic [HALO_COORD_W-1:0] bank_of(
        input logic [HALO_COORD_W-1:0] row,
        input logic [HALO_COORD_W-1:0] column,
        input int                      bank_count
    );
        logic [HALO_COORD_W-1:0] mask;
        mask = HALO_COORD_W'(bank_count - 1);
        return (row + column) & mask;
    endfunction

endpackage

// File: rtl/halo_rx_fifo.sv
// Per-neighbor entry FIFO: holds halo writes until the bank arbiter takes them.
// Latency: a push is visible at head the cycle after it is accepted.
// Backpressure: push while full is ignored here; the caller flags the overflow.
// Ports: clk/reset_n, push + push_entry, pop, head, count, full, empty.
module halo_rx_fifo
    import halo_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  halo_entry_t            push_entry,
    input  logic                   pop,
    output halo_entry_t            head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    halo_entry_t       mem_q [DEPTH];
    halo_entry_t       mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy is governed by the pointers and count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/halo_receiver.sv
// Halo exchange receiver: per-neighbor FIFOs arbitrated round-robin onto banked buffer writes.
// Latency: write strobe at cycle t gives buffer_write_enable at t+2 when the bank is uncontended.
// Backpressure: registered neighbor_cts with two entries of slack; pushes into a full FIFO drop and set overflow_error.
// Ports: exchange_start/neighbor_input_*/neighbor_exchange_done in; neighbor_cts, buffer_* (per bank),
//        exchange_complete, overflow_error out. HALO_RX_BOUNDS_CHECK_EN adds the sticky bounds_error output.
module halo_receiver
    import halo_pkg::*;
#(
    parameter int BANK_COUNT  = 32,
    parameter int TILE_SIZE   = HALO_TILE_SIZE,
    parameter int FIFO_DEPTH  = 4,
    parameter int VALUE_WIDTH = HALO_VALUE_W
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         exchange_start,
    input  logic [VALUE_WIDTH-1:0]       neighbor_input_value        [NEIGHBOR_COUNT],
    input  logic [$clog2(TILE_SIZE)-1:0] neighbor_input_row          [NEIGHBOR_COUNT],
    input  logic [$clog2(TILE_SIZE)-1:0] neighbor_input_column       [NEIGHBOR_COUNT],
    input  logic [NEIGHBOR_COUNT-1:0]    neighbor_input_write_enable,
    input  logic [NEIGHBOR_COUNT-1:0]    neighbor_exchange_done,
    output logic [NEIGHBOR_COUNT-1:0]    neighbor_cts,
    output logic [$clog2(TILE_SIZE)-1:0] buffer_row_write            [BANK_COUNT],
    output logic [$clog2(TILE_SIZE)-1:0] buffer_column_write         [BANK_COUNT],
    output logic [VALUE_WIDTH-1:0]       buffer_data_write           [BANK_COUNT],
    output logic [BANK_COUNT-1:0]        buffer_write_enable,
    output logic                         exchange_complete,
    output logic                         overflow_error
`ifdef HALO_RX_BOUNDS_CHECK_EN
    ,
    output logic                         bounds_error
`endif
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int PTR_W = $clog2(NEIGHBOR_COUNT);

    halo_state_e               state_q, state_d;
    logic [NEIGHBOR_COUNT-1:0] done_flags_q, done_flags_d;
    logic [PTR_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic [NEIGHBOR_COUNT-1:0] cts_q, cts_d;
    logic                      overflow_q, overflow_d;

    logic [BANK_COUNT-1:0]     buf_we_q, buf_we_d;
    logic [HALO_COORD_W-1:0]   buf_row_q [BANK_COUNT];
    logic [HALO_COORD_W-1:0]   buf_row_d [BANK_COUNT];
    logic [HALO_COORD_W-1:0]   buf_col_q [BANK_COUNT];
    logic [HALO_COORD_W-1:0]   buf_col_d [BANK_COUNT];
    logic [HALO_VALUE_W-1:0]   buf_dat_q [BANK_COUNT];
    logic [HALO_VALUE_W-1:0]   buf_dat_d [BANK_COUNT];

    halo_entry_t               in_entry   [NEIGHBOR_COUNT];
    halo_entry_t               fifo_head  [NEIGHBOR_COUNT];
    logic [CNT_W-1:0]          fifo_count [NEIGHBOR_COUNT];
    logic [CNT_W-1:0]          cnt_next   [NEIGHBOR_COUNT];
    logic [HALO_COORD_W-1:0]   head_bank  [NEIGHBOR_COUNT];
    logic [NEIGHBOR_COUNT-1:0] fifo_full, fifo_empty;
    logic [NEIGHBOR_COUNT-1:0] wr_req, push_ok, grant;
    logic [BANK_COUNT-1:0]     win_vld;
    halo_entry_t               win_dat [BANK_COUNT];

    // ---------------- ingress ----------------
`ifdef HALO_RX_BOUNDS_CHECK_EN
    logic [NEIGHBOR_COUNT-1:0] in_bounds;
    logic                      bounds_q, bounds_d;

    always_comb begin
        for (int i = 0; i < NEIGHBOR_COUNT; i++) begin
            in_bounds[i] = (32'(neighbor_input_row[i]) < TILE_SIZE) &&
                           (32'(neighbor_input_column[i]) < TILE_SIZE);
        end
    end

    assign bounds_d     = bounds_q | (|(neighbor_input_write_enable & ~in_bounds &
                                        {NEIGHBOR_COUNT{state_q != IDLE}}));
    assign bounds_error = bounds_q;
    assign wr_req       = neighbor_input_write_enable & in_bounds & {NEIGHBOR_COUNT{state_q != IDLE}};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) bounds_q <= 1'b0;
        else          bounds_q <= bounds_d;
    end
`else
    assign wr_req = neighbor_input_write_enable & {NEIGHBOR_COUNT{state_q != IDLE}};
`endif

    // Fullness is judged before this cycle's pop, so a full FIFO drops even while draining.
    assign push_ok    = wr_req & ~fifo_full;
    assign overflow_d = overflow_q | (|(wr_req & fifo_full));

    always_comb begin
        for (int i = 0; i < NEIGHBOR_COUNT; i++) begin
            in_entry[i].value  = neighbor_input_value[i];
            in_entry[i].row    = neighbor_input_row[i];
            in_entry[i].column = neighbor_input_column[i];
            head_bank[i]       = bank_of(fifo_head[i].row, fifo_head[i].column, BANK_COUNT);
        end
    end

    for (genvar i = 0; i < NEIGHBOR_COUNT; i++) begin : g_fifo
        halo_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk        (clk),
            .reset_n    (reset_n),
            .push       (push_ok[i]),
            .push_entry (in_entry[i]),
            .pop        (grant[i]),
            .head       (fifo_head[i]),
            .count      (fifo_count[i]),
            .full       (fifo_full[i]),
            .empty      (fifo_empty[i])
        );
    end

    // ---------------- per-bank round-robin arbitration ----------------
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx     = '0;
        grant   = '0;
        win_vld = '0;
        for (int b = 0; b < BANK_COUNT; b++) begin
            win_dat[b] = '0;
            for (int k = 0; k < NEIGHBOR_COUNT; k++) begin
                idx = rr_ptr_q + PTR_W'(k);
                if (!win_vld[b] && !fifo_empty[idx] && head_bank[idx] == HALO_COORD_W'(b)) begin
                    win_vld[b] = 1'b1;
                    win_dat[b] = fifo_head[idx];
                    grant[idx] = 1'b1;
                end
            end
        end
    end

    // One shared pointer advances whenever any bank granted.
    assign rr_ptr_d = (|grant) ? rr_ptr_q + PTR_W'(1) : rr_ptr_q;

    // Non-granted banks keep their last coordinates/data so the bus stays quiet.
    always_comb begin
        buf_we_d = win_vld;
        for (int b = 0; b < BANK_COUNT; b++) begin
            buf_row_d[b] = win_vld[b] ? win_dat[b].row    : buf_row_q[b];
            buf_col_d[b] = win_vld[b] ? win_dat[b].column : buf_col_q[b];
            buf_dat_d[b] = win_vld[b] ? win_dat[b].value  : buf_dat_q[b];
        end
    end

    // ---------------- clear-to-send ----------------
    // Threshold on post-update occupancy leaves room for the write already in flight
    // while the sender reacts to the registered cts.
    always_comb begin
        for (int i = 0; i < NEIGHBOR_COUNT; i++) begin
            cnt_next[i] = fifo_count[i] + CNT_W'(push_ok[i]) - CNT_W'(grant[i]);
            cts_d[i]    = (state_d == RECV) && (cnt_next[i] <= CNT_W'(FIFO_DEPTH - 2));
        end
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            done_flags_q <= '0;
        end else begin
            state_q      <= state_d;
            done_flags_q <= done_flags_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        done_flags_d = done_flags_q;
        case (state_q)
            IDLE: begin
                if (exchange_start) begin
                    state_d      = RECV;
                    done_flags_d = '0;
                end
            end
            RECV: begin
                done_flags_d = done_flags_q | neighbor_exchange_done;
                if (&done_flags_d) state_d = DRAIN;
            end
            DRAIN: begin
                if ((&fifo_empty) && !(|buf_we_q)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        exchange_complete = (state_q == DONE);
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q   <= '0;
            cts_q      <= '0;
            overflow_q <= 1'b0;
            buf_we_q   <= '0;
            buf_row_q  <= '{default: '0};
            buf_col_q  <= '{default: '0};
            buf_dat_q  <= '{default: '0};
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            cts_q      <= cts_d;
            overflow_q <= overflow_d;
            buf_we_q   <= buf_we_d;
            buf_row_q  <= buf_row_d;
            buf_col_q  <= buf_col_d;
            buf_dat_q  <= buf_dat_d;
        end
    end

    assign neighbor_cts        = cts_q;
    assign overflow_error      = overflow_q;
    assign buffer_write_enable = buf_we_q;
    assign buffer_row_write    = buf_row_q;
    assign buffer_column_write = buf_col_q;
    assign buffer_data_write   = buf_dat_q;

endmodule

// File: doc/halo_receiver.md
Name: halo_receiver

Overview:
- Receive end of the PPU neighbor halo exchange. Accepts value/row/column writes from the 8 neighbor PPUs into per-neighbor FIFOs.
- Arbitrates FIFO heads onto the BANK_COUNT-banked activation buffer write ports.
- Drives per-neighbor clear-to-send, and signals completion once every neighbor has declared exchange done and all data has been written.

Parameters:
- BANK_COUNT, 32, number of buffer banks (power of 2)
- TILE_SIZE, 256, tile row/column range; coordinate width is $clog2(TILE_SIZE)
- NEIGHBOR_COUNT, 8, number of neighbor links
- FIFO_DEPTH, 4, entries per neighbor FIFO (power of 2, >=4)
- VALUE_WIDTH, 8, activation width

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- exchange_start  in  1  pulse; opens a receive window
- neighbor_input_value[NEIGHBOR_COUNT]  in  VALUE_WIDTH  incoming value
- neighbor_input_row[NEIGHBOR_COUNT]  in  $clog2(TILE_SIZE)  target row
- neighbor_input_column[NEIGHBOR_COUNT]  in  $clog2(TILE_SIZE)  target column
- neighbor_input_write_enable[NEIGHBOR_COUNT]  in  1  write strobe
- neighbor_exchange_done[NEIGHBOR_COUNT]  in  1  neighbor has sent its last value
- neighbor_cts[NEIGHBOR_COUNT]  out  1  registered clear-to-send to each neighbor
- buffer_row_write[BANK_COUNT]  out  $clog2(TILE_SIZE)  bank write row
- buffer_column_write[BANK_COUNT]  out  $clog2(TILE_SIZE)  bank write column
- buffer_data_write[BANK_COUNT]  out  VALUE_WIDTH  bank write data
- buffer_write_enable[BANK_COUNT]  out  1  bank write strobe
- exchange_complete  out  1  one-cycle completion pulse
- overflow_error  out  1  sticky; a write arrived at a full FIFO

Behaviour:
- Reset: all FIFOs empty, state IDLE, every output 0, done flags and round-robin pointer cleared. Reset asserted mid-exchange discards all buffered data.
- Bank mapping: bank = (row + column) mod BANK_COUNT, computed on the low $clog2(BANK_COUNT) bits. Row and column pass through unchanged.
- FIFO push:
  - neighbor_input_write_enable[i] pushes into FIFO i in any state except IDLE.
  - Push to a full FIFO: the write is dropped and overflow_error is set until reset.
  - Writes in IDLE are ignored; no error is raised.
- CTS:
  - neighbor_cts[i] is registered.
  - High only in RECV, and only when FIFO i occupancy after the current cycle's push/pop is <= FIFO_DEPTH-2. This slack covers the one-cycle sender reaction time.
- Arbitration:
  - Each cycle, each bank grants at most one FIFO head mapped to it.
  - Winner is the first requester at or after rr_ptr, scanning modulo NEIGHBOR_COUNT.
  - Each granted FIFO pops one entry.
  - rr_ptr advances by 1 in any cycle with at least one grant.
  - Distinct banks are written in parallel.
- Output timing:
  - buffer_* outputs are registered.
  - Uncontended latency: input write enable at cycle t gives buffer_write_enable at t+2.
  - buffer_write_enable stays high for exactly one cycle per entry.
  - Non-enabled banks hold enable 0; their data/row/column are don't-care but stable.
- State machine:
  - IDLE: on exchange_start -> RECV; clear done flags.
  - RECV: neighbor_exchange_done[i] sets sticky done_flag[i]. When all flags are set -> DRAIN. A write and exchange_done in the same cycle still accepts the write.
  - DRAIN: cts all 0; pushes are still accepted. When all FIFOs are empty and no buffer write is pending in the output register -> DONE.
  - DONE: exchange_complete=1 for one cycle -> IDLE.
- exchange_start outside IDLE is ignored.
- All done flags already set on entry to RECV: transition to DRAIN on the next cycle.

Optional Feature:
- Macro HALO_RX_BOUNDS_CHECK_EN.
- Defined: a push with row >= TILE_SIZE or column >= TILE_SIZE is dropped and sets sticky output bounds_error (an extra 1-bit port, reset 0). This is relevant when TILE_SIZE is not a power of 2.
- Undefined: no check, no bounds_error port; coordinates are written as received.

Decomposition:
- Package halo_pkg: state enum (IDLE, RECV, DRAIN, DONE), NEIGHBOR_COUNT constant, bank_of(row, column) mapping function, FIFO entry struct {value, row, column}.
- Sub-module halo_rx_fifo: one synchronous FIFO per neighbor with push, pop, head, count, full and empty.

Test Plan:
- Reset mid-RECV with 3 entries buffered -> all outputs 0, no buffer writes after reset, state IDLE.
- Start, then neighbor 2 writes value 0x5A at row 3, column 4, then all done -> buffer_write_enable[7]=1 at t+2 with row 3, column 4, data 0x5A, then exactly one exchange_complete pulse.
- Neighbors 0 and 5 both target bank 9 in the same cycle with rr_ptr=3 -> neighbor 5 written first, neighbor 0 one cycle later, rr_ptr advances.
- Neighbor 1 writes every cycle while its bank is permanently contended -> neighbor_cts[1] drops when occupancy reaches 3 and overflow_error stays 0.
- Neighbor writes ignoring cts into a full FIFO -> overflow_error=1 and the write is dropped.
- All 8 exchange_done asserted the same cycle as the final writes -> DRAIN, every value written, then exchange_complete; a second exchange_start during DRAIN is ignored.
